// File: rtl/async_frame_receiver.sv
// Chunked message receiver: synchronizes an asynchronous frame enable and chunk
// strobe, assembles chunks LSB-first and publishes whole messages or flags bad frames.
module async_frame_receiver #(
  parameter int MSG_W       = 16,
  parameter int CHUNK_W     = 6,
  parameter int SYNC_STAGES = 2,
  localparam int NCHUNK     = (MSG_W + CHUNK_W - 1) / CHUNK_W,
  localparam int CNT_W      = $clog2(NCHUNK + 2),
  localparam int BUF_W      = NCHUNK * CHUNK_W
) (
  input  logic               clk_receive,
  input  logic               rst_n,
  input  logic               transmit_ctrl,
  input  logic               packet_pulse,
  input  logic [CHUNK_W-1:0] din,
  output logic [MSG_W-1:0]   read_buffer,
  output logic               msg_valid,
  output logic               frame_err,
  output logic [CNT_W-1:0]   chunk_count
);

  localparam logic [CNT_W-1:0] NCHUNK_C = CNT_W'(NCHUNK);
  localparam logic [CNT_W-1:0] SAT_C    = CNT_W'(NCHUNK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ctrl_sync_q;
  logic [SYNC_STAGES-1:0] pulse_sync_q;
  logic                   pulse_prev_q;
  logic                   ctrl_s;
  logic                   pulse_s;
  logic                   strobe_s;

  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MSG_W-1:0]   rb_q, rb_d;
  logic               mv_q, mv_d;
  logic               fe_q, fe_d;

  assign ctrl_s   = ctrl_sync_q[SYNC_STAGES-1];
  assign pulse_s  = pulse_sync_q[SYNC_STAGES-1];
  assign strobe_s = pulse_s & ~pulse_prev_q;

  // din is held stable by the sender while the pulse is high, so only controls are synchronized
  always_ff @(posedge clk_receive or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_sync_q  <= '0;
      pulse_sync_q <= '0;
      pulse_prev_q <= 1'b0;
    end else begin
      ctrl_sync_q  <= {ctrl_sync_q[SYNC_STAGES-2:0], transmit_ctrl};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], packet_pulse};
      pulse_prev_q <= pulse_s;
    end
  end

  always_ff @(posedge clk_receive or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl_s) begin
          state_d = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (!ctrl_s) begin
          state_d = CHECK;
        end else begin
          state_d = RECV;
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chunk_d = strobe_s ? din : chunk_q;
    buf_d   = buf_q;
    count_d = count_q;
    rb_d    = rb_q;
    mv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_s) begin
          buf_d   = '0;
          count_d = '0;
        end else begin
          buf_d   = buf_q;
        end
      end
      RECV: begin
        // A strobe arriving together with the frame end is still taken before CHECK
        if (strobe_s) begin
          if (count_q < NCHUNK_C) begin
            buf_d = (buf_q >> CHUNK_W) | (BUF_W'(chunk_d) << (BUF_W - CHUNK_W));
          end else begin
            buf_d = buf_q;
          end
          if (count_q < SAT_C) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = count_q;
          end
        end else begin
          buf_d = buf_q;
        end
      end
      CHECK: begin
        if (count_q == NCHUNK_C) begin
          rb_d = buf_q[MSG_W-1:0];
          mv_d = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
      default: begin
        buf_d = buf_q;
      end
    endcase
  end

  always_ff @(posedge clk_receive or negedge rst_n) begin
    if (!rst_n) begin
      chunk_q <= '0;
      buf_q   <= '0;
      count_q <= '0;
      rb_q    <= '0;
      mv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      chunk_q <= chunk_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      rb_q    <= rb_d;
      mv_q    <= mv_d;
      fe_q    <= fe_d;
    end
  end

  assign read_buffer = rb_q;
  assign msg_valid   = mv_q;
  assign frame_err   = fe_q;
  assign chunk_count = count_q;

endmodule

// File: tb/tb_async_frame_receiver.sv
// Directed bench for async_frame_receiver: table of frames plus hand-written
// sequences for ctrl glitch, idle strobes and mid-frame reset.
module tb_async_frame_receiver;

  localparam int SYNC = 2;

  logic        clk_receive   = 1'b0;
  logic        rst_n         = 1'b0;
  logic        transmit_ctrl = 1'b0;
  logic        packet_pulse  = 1'b0;
  logic [5:0]  din           = 6'h00;
  logic [15:0] read_buffer;
  logic        msg_valid;
  logic        frame_err;
  logic [2:0]  chunk_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mv_tot = 0;
  int fe_tot = 0;
  int both_tot = 0;
  int last_mv = 0;
  int drop_cyc = 0;

  typedef struct {
    int               n;
    logic [4:0][5:0]  ch;
    bit               coinc;
    int               exp_mv;
    int               exp_fe;
    logic [15:0]      exp_rb;
    logic [2:0]       exp_cnt;
  } frame_t;

  frame_t frames[7];

  async_frame_receiver #(.MSG_W(16), .CHUNK_W(6), .SYNC_STAGES(SYNC)) dut (
    .clk_receive  (clk_receive),
    .rst_n        (rst_n),
    .transmit_ctrl(transmit_ctrl),
    .packet_pulse (packet_pulse),
    .din          (din),
    .read_buffer  (read_buffer),
    .msg_valid    (msg_valid),
    .frame_err    (frame_err),
    .chunk_count  (chunk_count)
  );

  always #5 clk_receive = ~clk_receive;

  always @(posedge clk_receive) cyc <= cyc + 1;

  always @(negedge clk_receive) begin
    if (msg_valid) begin
      mv_tot  <= mv_tot + 1;
      last_mv <= cyc;
    end
    if (frame_err) fe_tot <= fe_tot + 1;
    if (msg_valid && frame_err) both_tot <= both_tot + 1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic frame_t mk(input int n, input logic [5:0] c0, input logic [5:0] c1,
                                input logic [5:0] c2, input logic [5:0] c3, input logic [5:0] c4,
                                input bit coinc, input int mv, input int fe,
                                input logic [15:0] rb, input logic [2:0] cnt);
    frame_t f;
    f.n = n;
    f.ch = {c4, c3, c2, c1, c0};
    f.coinc = coinc;
    f.exp_mv = mv;
    f.exp_fe = fe;
    f.exp_rb = rb;
    f.exp_cnt = cnt;
    return f;
  endfunction

  task automatic send_chunk(input logic [5:0] d, input bit drop_with);
    din = d;
    packet_pulse = 1'b1;
    if (drop_with) begin
      transmit_ctrl = 1'b0;
      drop_cyc = cyc;
    end
    repeat (5) @(negedge clk_receive);
    packet_pulse = 1'b0;
    repeat (5) @(negedge clk_receive);
  endtask

  task automatic run_frame(input int idx, input frame_t f);
    int mv0, fe0, b0;
    mv0 = mv_tot;
    fe0 = fe_tot;
    b0  = both_tot;
    transmit_ctrl = 1'b1;
    repeat (4) @(negedge clk_receive);
    for (int i = 0; i < f.n; i++) send_chunk(f.ch[i], f.coinc && (i == f.n - 1));
    if (!f.coinc) begin
      transmit_ctrl = 1'b0;
      drop_cyc = cyc;
    end
    repeat (12) @(negedge clk_receive);
    check($sformatf("f%0d msg_valid pulses", idx), mv_tot - mv0, f.exp_mv);
    check($sformatf("f%0d frame_err pulses", idx), fe_tot - fe0, f.exp_fe);
    check($sformatf("f%0d both high", idx), both_tot - b0, 0);
    check($sformatf("f%0d read_buffer", idx), read_buffer, f.exp_rb);
    check($sformatf("f%0d chunk_count", idx), chunk_count, f.exp_cnt);
    if (f.exp_mv == 1 && !f.coinc)
      check($sformatf("f%0d latency", idx), last_mv - drop_cyc, SYNC + 2);
  endtask

  initial begin
    int mv0, fe0;
    frames[0] = mk(3, 6'h15, 6'h2A, 6'h3F, 6'h00, 6'h00, 1'b0, 1, 0, 16'hFA95, 3'd3);
    frames[1] = mk(2, 6'h15, 6'h2A, 6'h00, 6'h00, 6'h00, 1'b0, 0, 1, 16'hFA95, 3'd2);
    frames[2] = mk(5, 6'h15, 6'h2A, 6'h3F, 6'h01, 6'h02, 1'b0, 0, 1, 16'hFA95, 3'd4);
    frames[3] = mk(3, 6'h01, 6'h02, 6'h03, 6'h00, 6'h00, 1'b0, 1, 0, 16'h3081, 3'd3);
    frames[4] = mk(3, 6'h15, 6'h2A, 6'h3F, 6'h00, 6'h00, 1'b1, 1, 0, 16'hFA95, 3'd3);
    frames[5] = mk(0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 0, 1, 16'hFA95, 3'd0);
    frames[6] = mk(1, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 0, 1, 16'hFA95, 3'd1);

    repeat (3) @(negedge clk_receive);
    check("reset read_buffer", read_buffer, 16'h0000);
    check("reset msg_valid", msg_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset chunk_count", chunk_count, 3'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_receive);

    for (int i = 0; i < 7; i++) run_frame(i, frames[i]);

    // strobes with the frame enable low must be ignored
    mv0 = mv_tot;
    fe0 = fe_tot;
    for (int i = 0; i < 4; i++) begin
      din = 6'(i + 9);
      packet_pulse = 1'b1;
      repeat (4) @(negedge clk_receive);
      packet_pulse = 1'b0;
      repeat (4) @(negedge clk_receive);
    end
    repeat (6) @(negedge clk_receive);
    check("idle strobes chunk_count", chunk_count, 3'd1);
    check("idle strobes read_buffer", read_buffer, 16'hFA95);
    check("idle strobes pulses", (mv_tot - mv0) + (fe_tot - fe0), 0);

    // one-cycle ctrl drop: frame closes, new frame starts without loss
    mv0 = mv_tot;
    transmit_ctrl = 1'b1;
    repeat (4) @(negedge clk_receive);
    send_chunk(6'h01, 1'b0);
    send_chunk(6'h02, 1'b0);
    send_chunk(6'h03, 1'b0);
    transmit_ctrl = 1'b0;
    drop_cyc = cyc;
    @(negedge clk_receive);
    transmit_ctrl = 1'b1;
    repeat (8) @(negedge clk_receive);
    check("glitch first read_buffer", read_buffer, 16'h3081);
    check("glitch first pulses", mv_tot - mv0, 1);
    check("glitch latency", last_mv - drop_cyc, SYNC + 2);
    check("glitch new frame count", chunk_count, 3'd0);
    send_chunk(6'h15, 1'b0);
    send_chunk(6'h2A, 1'b0);
    send_chunk(6'h3F, 1'b0);
    transmit_ctrl = 1'b0;
    repeat (12) @(negedge clk_receive);
    check("glitch second read_buffer", read_buffer, 16'hFA95);
    check("glitch second pulses", mv_tot - mv0, 2);
    check("glitch second count", chunk_count, 3'd3);

    // reset in the middle of a frame
    transmit_ctrl = 1'b1;
    repeat (4) @(negedge clk_receive);
    send_chunk(6'h15, 1'b0);
    send_chunk(6'h2A, 1'b0);
    mv0 = mv_tot;
    fe0 = fe_tot;
    rst_n = 1'b0;
    #1;
    check("midreset read_buffer", read_buffer, 16'h0000);
    check("midreset chunk_count", chunk_count, 3'd0);
    check("midreset msg_valid", msg_valid, 1'b0);
    transmit_ctrl = 1'b0;
    repeat (3) @(negedge clk_receive);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_receive);
    check("midreset no pulses", (mv_tot - mv0) + (fe_tot - fe0), 0);
    run_frame(7, mk(3, 6'h01, 6'h02, 6'h03, 6'h00, 6'h00, 1'b0, 1, 0, 16'h3081, 3'd3));

    check("never both high", both_tot, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/async_frame_receiver.md
ASYNC_FRAME_RECEIVER -- requirements
Module: async_frame_receiver

Interface
REQ-001 SHALL have parameter MSG_W, default 16: message width in bits, MSG_W >= 1.
REQ-002 SHALL have parameter CHUNK_W, default 6: chunk width per packet_pulse, 1 <= CHUNK_W <= MSG_W.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop stages on each asynchronous control input, >= 2.
REQ-004 SHALL derive NCHUNK = ceil(MSG_W/CHUNK_W) and CNT_W = clog2(NCHUNK+2) internally.
REQ-005 clk_receive  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-007 transmit_ctrl  input  1  asynchronous frame enable; high for the whole frame.
REQ-008 packet_pulse  input  1  asynchronous chunk strobe; one rising edge per chunk.
REQ-009 din  input  CHUNK_W  chunk data; sender holds it stable while packet_pulse is high.
REQ-010 read_buffer  output  MSG_W  last good message; first chunk in LSBs.
REQ-011 msg_valid  output  1  one-cycle pulse when read_buffer updates.
REQ-012 frame_err  output  1  one-cycle pulse when a frame ends with chunk count != NCHUNK.
REQ-013 chunk_count  output  CNT_W  chunks accepted in current or last frame, saturating at NCHUNK+1.

Function
REQ-014 SHALL pass transmit_ctrl and packet_pulse each through SYNC_STAGES flops (ctrl_s, pulse_s); din SHALL NOT be synchronized.
REQ-015 SHALL detect a chunk strobe as pulse_s high with its previous-cycle value low (one cycle per pulse).
REQ-016 SHALL capture din into a CHUNK_W register on the strobe cycle; the register feeds the shift buffer in the same cycle.
REQ-017 SHALL implement states IDLE, RECV, CHECK; reset state IDLE.
REQ-018 IDLE: on ctrl_s high -> RECV, clear shift buffer (NCHUNK*CHUNK_W bits) and chunk_count to 0; strobes in IDLE ignored.
REQ-019 RECV: each strobe shifts buffer right by CHUNK_W with new chunk into the top CHUNK_W bits, and increments chunk_count, saturating at NCHUNK+1.
REQ-020 RECV: chunks beyond NCHUNK SHALL NOT shift the buffer; only the count moves (to NCHUNK+1).
REQ-021 RECV: on ctrl_s low -> CHECK; a strobe in that same cycle SHALL be accepted first.
REQ-022 CHECK: if chunk_count == NCHUNK, load read_buffer with buffer bits [MSG_W-1:0] and pulse msg_valid; else leave read_buffer unchanged and pulse frame_err; always -> IDLE next cycle.
REQ-023 msg_valid and frame_err SHALL never be high together and SHALL be high exactly one cycle per frame.
REQ-024 Top (NCHUNK*CHUNK_W - MSG_W) bits of the last chunk SHALL be discarded.
REQ-025 Latency: ctrl_s falling observed -> CHECK next edge -> read_buffer/msg_valid visible the following edge; transmit_ctrl pin to msg_valid SHALL be SYNC_STAGES+2 cycles.
REQ-026 ctrl_s low then high again while in CHECK SHALL be handled by IDLE on the next cycle (new frame not lost if ctrl held high).
REQ-027 chunk_count SHALL hold its value through IDLE until the next frame start.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, synchronizer flops 0, read_buffer 0, shift buffer 0, chunk_count 0, msg_valid 0, frame_err 0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no msg_valid or frame_err pulse; first frame after release behaves as from power-up.
REQ-030 Deassertion of rst_n SHALL take effect synchronously to clk_receive (release-synchronized by the integrating level).

Verification (MSG_W=16, CHUNK_W=6, NCHUNK=3)
REQ-031 Frame with chunks 0x15, 0x2A, 0x3F -> read_buffer = 0xFA95, msg_valid one cycle, chunk_count = 3, frame_err 0.
REQ-032 Frame with 2 chunks -> frame_err one cycle, read_buffer keeps prior 0xFA95, chunk_count = 2.
REQ-033 Frame with 5 chunks (0x15,0x2A,0x3F,0x01,0x02) -> frame_err, chunk_count = 4, read_buffer unchanged.
REQ-034 Third strobe coincident with transmit_ctrl fall at pin level -> chunk accepted, msg_valid, read_buffer = 0xFA95.
REQ-035 rst_n low after second chunk, released, then clean frame 0x01,0x02,0x03 -> no pulse at reset, then read_buffer = 0x3081.
REQ-036 packet_pulse toggling while transmit_ctrl low -> no state change, chunk_count unchanged, no pulses.
